// File: rtl/reg_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_master_if
// Brief   : Command/response handshake and en/rd/wr/be register-bus bundle.
// Revision: 1.0
// ============================================================================
interface reg_bus_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic                  cmd_byte;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_error;

    logic                  bus_en;
    logic                  bus_rd;
    logic                  bus_wr;
    logic [1:0]            bus_be;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_byte, cmd_addr, cmd_wdata, bus_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_error,
               bus_en, bus_rd, bus_wr, bus_be, bus_addr, bus_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_byte, cmd_addr, cmd_wdata, bus_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error,
               bus_en, bus_rd, bus_wr, bus_be, bus_addr, bus_wdata
    );
endinterface
`default_nettype wire

// File: rtl/reg_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_master
// Brief   : Sequences setup/strobe/hold/recover register-bus accesses from
//           valid/ready word or byte commands. Defining
//           REG_BUS_MASTER_VERIFY_EN adds a read-back check after every write.
// Revision: 1.0
// ============================================================================
module reg_bus_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int READ_WAIT  = 3
) (
    input  wire              clk,
    input  wire              reset,
    reg_bus_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_HOLD    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    localparam logic [3:0] c_wait_init = 4'(READ_WAIT - 1);

    state_t                r_state;
    logic [3:0]            r_wait_cnt;
    logic                  r_is_read;
    logic                  r_byte;
    logic                  r_lane;

    logic [1:0]            w_be_new;
    logic [DATA_WIDTH-1:0] w_wdata_new;
    logic [7:0]            w_lane;
    logic [DATA_WIDTH-1:0] w_rsp_new;

`ifdef REG_BUS_MASTER_VERIFY_EN
    logic                  r_verify;
    logic [1:0]            r_cmd_be;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_mismatch;
`endif

    always_comb begin
        w_be_new    = bus.cmd_byte ? (bus.cmd_addr[0] ? 2'b10 : 2'b01) : 2'b11;
        w_wdata_new = bus.cmd_byte ? {bus.cmd_wdata[7:0], bus.cmd_wdata[7:0]} : bus.cmd_wdata;
        w_lane      = r_lane ? bus.bus_rdata[15:8] : bus.bus_rdata[7:0];
        w_rsp_new   = r_byte ? {8'h00, w_lane} : bus.bus_rdata;
    end

`ifdef REG_BUS_MASTER_VERIFY_EN
    // bus_be is still driven during STROBE, so it masks the compare directly.
    always_comb begin
        w_mask     = {{8{bus.bus_be[1]}}, {8{bus.bus_be[0]}}};
        w_mismatch = |((bus.bus_rdata ^ bus.bus_wdata) & w_mask);
    end
`else
    assign bus.rsp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 4'd0;
            r_is_read     <= 1'b0;
            r_byte        <= 1'b0;
            r_lane        <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.bus_en    <= 1'b0;
            bus.bus_rd    <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.bus_be    <= 2'b00;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
`ifdef REG_BUS_MASTER_VERIFY_EN
            bus.rsp_error <= 1'b0;
            r_verify      <= 1'b0;
            r_cmd_be      <= 2'b00;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
`ifdef REG_BUS_MASTER_VERIFY_EN
            bus.rsp_error <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        r_state       <= S_SETUP;
                        bus.cmd_ready <= 1'b0;
                        bus.bus_addr  <= {1'b0, bus.cmd_addr[ADDR_WIDTH-1:1]};
                        bus.bus_be    <= w_be_new;
                        bus.bus_wdata <= w_wdata_new;
                        r_is_read     <= ~bus.cmd_write;
                        r_byte        <= bus.cmd_byte;
                        r_lane        <= bus.cmd_addr[0];
`ifdef REG_BUS_MASTER_VERIFY_EN
                        r_cmd_be      <= w_be_new;
`endif
                    end
                end
                S_SETUP: begin
                    r_state    <= S_STROBE;
                    bus.bus_en <= 1'b1;
                    if (r_is_read) begin
                        bus.bus_rd <= 1'b1;
                        r_wait_cnt <= c_wait_init;
                    end else begin
                        bus.bus_wr <= 1'b1;
                    end
                end
                S_STROBE: begin
                    if (!r_is_read) begin
                        bus.bus_wr <= 1'b0;
                        r_state    <= S_HOLD;
                    end else if (r_wait_cnt == 4'd0) begin
                        // Last read-strobe cycle: capture and present the response.
                        bus.bus_rd    <= 1'b0;
                        r_state       <= S_HOLD;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= w_rsp_new;
`ifdef REG_BUS_MASTER_VERIFY_EN
                        bus.rsp_error <= r_verify & w_mismatch;
`endif
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    bus.bus_en <= 1'b0;
                    bus.bus_be <= 2'b00;
                    r_state    <= S_RECOVER;
                end
                S_RECOVER: begin
`ifdef REG_BUS_MASTER_VERIFY_EN
                    if (!r_is_read) begin
                        // Re-run the same address and lanes as a read-back.
                        r_state    <= S_SETUP;
                        r_is_read  <= 1'b1;
                        r_verify   <= 1'b1;
                        bus.bus_be <= r_cmd_be;
                    end else begin
                        r_state       <= S_IDLE;
                        r_verify      <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
`else
                    r_state       <= S_IDLE;
                    bus.cmd_ready <= 1'b1;
`endif
                end
                default: begin
                    r_state       <= S_IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.bus_en    <= 1'b0;
                    bus.bus_rd    <= 1'b0;
                    bus.bus_wr    <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_reg_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bus_master
// Brief   : Directed scoreboard bench for reg_bus_master with a register-file model.
// Revision: 1.0
// ============================================================================
module tb_reg_bus_master;
    localparam int RW = 3;
`ifdef REG_BUS_MASTER_VERIFY_EN
    localparam int C_WR_LAT = RW + 7;
`else
    localparam int C_WR_LAT = 4;
`endif

    typedef struct packed {
        logic        wr;
        logic [6:0]  addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        bit          wr;
        bit          byt;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [6:0]  e_addr;
        logic [1:0]  e_be;
        logic [15:0] e_wdata;
        logic [15:0] e_rsp;
        bit          e_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic corrupt = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];
    logic [15:0] mem [128] = '{default: 16'h0000};

    reg_bus_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bif ();

    reg_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_WAIT(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model; corrupt flips bit 0 of read data.
    assign bif.bus_rdata = mem[bif.bus_addr[6:0]] ^ (corrupt ? 16'h0001 : 16'h0000);
    always @(posedge clk) begin
        if (bif.bus_en && bif.bus_wr) begin
            if (bif.bus_be[0]) mem[bif.bus_addr[6:0]][7:0]  <= bif.bus_wdata[7:0];
            if (bif.bus_be[1]) mem[bif.bus_addr[6:0]][15:8] <= bif.bus_wdata[15:8];
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic vec_t mk(bit wr, bit byt, logic [7:0] a, logic [15:0] wd,
                                logic [6:0] ea, logic [1:0] eb, logic [15:0] ewd,
                                logic [15:0] ersp, bit eerr);
        vec_t v;
        v.wr = wr; v.byt = byt; v.addr = a; v.wdata = wd;
        v.e_addr = ea; v.e_be = eb; v.e_wdata = ewd; v.e_rsp = ersp; v.e_err = eerr;
        return v;
    endfunction

    task automatic monitor();
        bit prev_rd = 1'b0;
        bit prev_wr = 1'b0;
        int rd_run = 0;
        int wr_run = 0;
        rsp_exp_t r;
        bus_exp_t b;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rd = 1'b0; prev_wr = 1'b0; rd_run = 0; wr_run = 0;
            end else begin
                chk("strobe_overlap", 32'(bif.bus_rd & bif.bus_wr), 32'd0);
                chk("strobe_without_en", 32'((bif.bus_rd | bif.bus_wr) & ~bif.bus_en), 32'd0);
                if (bif.rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1 data %0h expected none", bif.rsp_data);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rsp_data", 32'(bif.rsp_data), 32'(r.data));
                        chk("rsp_error", 32'(bif.rsp_error), 32'(r.err));
                        chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                    end
                end
                if ((bif.bus_wr && !prev_wr) || (bif.bus_rd && !prev_rd)) begin
                    if (bus_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL strobe_unexpected: got addr %0h expected no strobe", bif.bus_addr);
                    end else begin
                        b = bus_q.pop_front();
                        chk("bus_kind_wr", 32'(bif.bus_wr), 32'(b.wr));
                        chk("bus_addr", 32'(bif.bus_addr), 32'(b.addr));
                        chk("bus_be", 32'(bif.bus_be), 32'(b.be));
                        if (b.wr) chk("bus_wdata", 32'(bif.bus_wdata), 32'(b.wdata));
                    end
                end
                if (bif.bus_wr) wr_run++;
                else if (prev_wr) begin chk("wr_len", 32'(wr_run), 32'd1); wr_run = 0; end
                if (bif.bus_rd) rd_run++;
                else if (prev_rd) begin chk("rd_len", 32'(rd_run), 32'(RW)); rd_run = 0; end
                prev_wr = bif.bus_wr;
                prev_rd = bif.bus_rd;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where cmd_ready is high again.
    task automatic send(input vec_t v, input bit keep);
        int n;
        bif.cmd_valid = 1'b1;
        bif.cmd_write = v.wr;
        bif.cmd_byte  = v.byt;
        bif.cmd_addr  = v.addr;
        bif.cmd_wdata = v.wdata;
        n = 0;
        while (!bif.cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_ready_before_send", 32'(bif.cmd_ready), 32'd1);
        bus_q.push_back('{v.wr, v.e_addr, v.e_be, v.e_wdata});
        if (!v.wr) rsp_q.push_back('{v.e_rsp, 1'b0, cyc + RW + 2});
`ifdef REG_BUS_MASTER_VERIFY_EN
        else begin
            bus_q.push_back('{1'b0, v.e_addr, v.e_be, v.e_wdata});
            rsp_q.push_back('{v.e_rsp, v.e_err, cyc + RW + 6});
        end
`endif
        @(negedge clk);
        if (!keep) bif.cmd_valid = 1'b0;
        chk("cmd_ready_busy", 32'(bif.cmd_ready), 32'd0);
        n = 0;
        while (!bif.cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk(v.wr ? "write_latency" : "read_latency", 32'(n), v.wr ? 32'(C_WR_LAT) : 32'(RW + 3));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            monitor();
        join_none

        bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_byte = 1'b0;
        bif.cmd_addr = 8'h00; bif.cmd_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bif.rsp_data), 32'd0);
        chk("rst_rsp_error", 32'(bif.rsp_error), 32'd0);
        chk("rst_bus_en", 32'(bif.bus_en), 32'd0);
        chk("rst_bus_rd", 32'(bif.bus_rd), 32'd0);
        chk("rst_bus_wr", 32'(bif.bus_wr), 32'd0);
        chk("rst_bus_be", 32'(bif.bus_be), 32'd0);
        chk("rst_bus_addr", 32'(bif.bus_addr), 32'd0);
        chk("rst_bus_wdata", 32'(bif.bus_wdata), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Write to 0x10 aborted by reset during its strobe.
        bif.cmd_valid = 1'b1; bif.cmd_write = 1'b1; bif.cmd_byte = 1'b0;
        bif.cmd_addr = 8'h10; bif.cmd_wdata = 16'h1234;
        bus_q.push_back('{1'b1, 7'h08, 2'b11, 16'h1234});
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        chk("setup_bus_en", 32'(bif.bus_en), 32'd0);
        @(negedge clk);
        chk("strobe_bus_wr", 32'(bif.bus_wr), 32'd1);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_bus_en", 32'(bif.bus_en), 32'd0);
        chk("abort_bus_wr", 32'(bif.bus_wr), 32'd0);
        chk("abort_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        chk("abort_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);

        // Individual commands; mem[0x08] is 0x1234 from the aborted write's strobe edge.
        send(mk(1, 0, 8'h00, 16'hDEAD, 7'h00, 2'b11, 16'hDEAD, 16'hDEAD, 0), 0);
        send(mk(1, 0, 8'h02, 16'hBEEF, 7'h01, 2'b11, 16'hBEEF, 16'hBEEF, 0), 0);
        send(mk(0, 0, 8'h02, 16'h0000, 7'h01, 2'b11, 16'h0000, 16'hBEEF, 0), 0);
        send(mk(0, 0, 8'h03, 16'h0000, 7'h01, 2'b11, 16'h0000, 16'hBEEF, 0), 0);
        send(mk(1, 1, 8'h11, 16'h00FF, 7'h08, 2'b10, 16'hFFFF, 16'h00FF, 0), 0);
        send(mk(0, 1, 8'h11, 16'h0000, 7'h08, 2'b10, 16'h0000, 16'h00FF, 0), 0);
        send(mk(0, 1, 8'h10, 16'h0000, 7'h08, 2'b01, 16'h0000, 16'h0034, 0), 0);

        // Back-to-back with cmd_valid held high.
        send(mk(1, 0, 8'h20, 16'h1111, 7'h10, 2'b11, 16'h1111, 16'h1111, 0), 1);
        send(mk(1, 1, 8'h21, 16'h0022, 7'h10, 2'b10, 16'h2222, 16'h0022, 0), 1);
        send(mk(0, 0, 8'h20, 16'h0000, 7'h10, 2'b11, 16'h0000, 16'h2211, 0), 1);
        send(mk(1, 1, 8'h40, 16'h12AB, 7'h20, 2'b01, 16'hABAB, 16'h00AB, 0), 1);
        send(mk(0, 1, 8'h40, 16'h0000, 7'h20, 2'b01, 16'h0000, 16'h00AB, 0), 1);
        send(mk(0, 1, 8'h41, 16'h0000, 7'h20, 2'b10, 16'h0000, 16'h0000, 0), 1);
        send(mk(1, 0, 8'hFE, 16'hA55A, 7'h7F, 2'b11, 16'hA55A, 16'hA55A, 0), 1);
        send(mk(0, 1, 8'hFF, 16'h0000, 7'h7F, 2'b10, 16'h0000, 16'h00A5, 0), 1);
        send(mk(0, 0, 8'hFF, 16'h0000, 7'h7F, 2'b11, 16'h0000, 16'hA55A, 0), 1);
        send(mk(0, 0, 8'h00, 16'h0000, 7'h00, 2'b11, 16'h0000, 16'hDEAD, 0), 1);
        bif.cmd_valid = 1'b0;

`ifdef REG_BUS_MASTER_VERIFY_EN
        @(negedge clk);
        corrupt = 1'b1;
        send(mk(1, 0, 8'h04, 16'hCAFE, 7'h02, 2'b11, 16'hCAFE, 16'hCAFF, 1), 0);
        corrupt = 1'b0;
        send(mk(1, 0, 8'h04, 16'hCAFE, 7'h02, 2'b11, 16'hCAFE, 16'hCAFE, 0), 0);
`endif

        repeat (5) @(negedge clk);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
